// File: rtl/debounce_bank.sv
// -----------------------------------------------------------------------------
// debounce_bank
//   Multi-channel push-button conditioner. Each channel has a 2-FF
//   synchroniser with selectable polarity, a stability counter advanced by a
//   shared sample tick, registered press/release pulses, and a hold FSM that
//   produces a long-press pulse followed by auto-repeat pulses while held.
//
// Ports
//   clk       in   1       system clock, all logic on posedge
//   rst_n     in   1       asynchronous active-low reset
//   pb        in   NUM_CH  raw asynchronous button inputs, bit i = channel i
//   pb_state  out  NUM_CH  debounced level, 1 = pressed
//   pb_down   out  NUM_CH  1-cycle pulse on accepted press
//   pb_up     out  NUM_CH  1-cycle pulse on accepted release
//   pb_long   out  NUM_CH  1-cycle pulse after LONG_TICKS ticks held
//   pb_rep    out  NUM_CH  1-cycle pulse every REPEAT_TICKS ticks after pb_long
//
// Hold FSM (per channel)
//   state   | meaning
//   H_IDLE  | button released, hold timer parked at 0
//   H_PRESS | pressed, counting ticks toward the long-press pulse
//   H_HELD  | long press reported, counting ticks between repeat pulses
// -----------------------------------------------------------------------------
module debounce_bank #(
  parameter int NUM_CH       = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int CNT_W        = 4,
  parameter int PRESCALE     = 1,
  parameter int LONG_TICKS   = 64,
  parameter int REPEAT_TICKS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] pb,
  output logic [NUM_CH-1:0] pb_state,
  output logic [NUM_CH-1:0] pb_down,
  output logic [NUM_CH-1:0] pb_up,
  output logic [NUM_CH-1:0] pb_long,
  output logic [NUM_CH-1:0] pb_rep
);

  localparam logic [NUM_CH-1:0] POL_MASK = (ACTIVE_LOW != 0) ? '1 : '0;

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  localparam int HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ?
                            ((LONG_TICKS > 1) ? LONG_TICKS : 1) :
                            ((REPEAT_TICKS > 1) ? REPEAT_TICKS : 1);
  localparam int HT_W = $clog2(HOLD_MAX + 1);
  localparam logic [HT_W-1:0] LONG_LAST = (LONG_TICKS > 0)   ? HT_W'(LONG_TICKS - 1)   : '0;
  localparam logic [HT_W-1:0] REP_LAST  = (REPEAT_TICKS > 0) ? HT_W'(REPEAT_TICKS - 1) : '0;

  typedef enum logic [1:0] {
    H_IDLE  = 2'd0,
    H_PRESS = 2'd1,
    H_HELD  = 2'd2
  } hold_state_t;

  // ---------------------------------------------------------------------------
  // Shared sample-tick prescaler
  // ---------------------------------------------------------------------------
  logic [PS_W-1:0] ps_cnt;
  logic            tick;

  assign tick = (ps_cnt == PS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt <= '0;
    end else if (tick) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Synchroniser; polarity is folded into the first stage so everything
  // downstream sees 1 = pressed.
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] sync0;
  logic [NUM_CH-1:0] sync1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= pb ^ POL_MASK;
      sync1 <= sync0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stability counters. accept[i] marks the cycle in which channel i's
  // debounced level flips; the hold FSMs consume the same-cycle press/release
  // events so their timing is referenced to the pb_down/pb_up edge itself.
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] down_evt;
  logic [NUM_CH-1:0] up_evt;

  assign down_evt = accept & ~pb_state;
  assign up_evt   = accept &  pb_state;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_stab
    logic [CNT_W-1:0] cnt;
    logic             idle;

    assign idle      = (pb_state[g] == sync1[g]);
    assign accept[g] = !idle && tick && (cnt == '1);

    // Any return to the current level clears the count immediately, so a
    // glitch restarts the full stability window.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (idle || accept[g]) begin
        cnt <= '0;
      end else if (tick) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pb_state <= '0;
      pb_down  <= '0;
      pb_up    <= '0;
    end else begin
      pb_state <= pb_state ^ accept;
      pb_down  <= down_evt;
      pb_up    <= up_evt;
    end
  end

  // ---------------------------------------------------------------------------
  // Hold FSMs
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    if (LONG_TICKS > 0) begin : g_hold
      hold_state_t     state;
      logic [HT_W-1:0] htmr;
      logic            long_q;
      logic            rep_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state  <= H_IDLE;
          htmr   <= '0;
          long_q <= 1'b0;
          rep_q  <= 1'b0;
        end else begin
          long_q <= 1'b0;
          rep_q  <= 1'b0;
          // A release always wins: a long/repeat due in the same cycle is dropped.
          if (up_evt[g]) begin
            state <= H_IDLE;
            htmr  <= '0;
          end else begin
            case (state)
              H_IDLE: begin
                htmr <= '0;
                if (down_evt[g]) begin
                  state <= H_PRESS;
                end
              end
              H_PRESS: begin
                if (tick) begin
                  if (htmr == LONG_LAST) begin
                    long_q <= 1'b1;
                    htmr   <= '0;
                    state  <= H_HELD;
                  end else begin
                    htmr <= htmr + 1'b1;
                  end
                end
              end
              H_HELD: begin
                // With repeat disabled the timer simply parks until release.
                if ((REPEAT_TICKS > 0) && tick) begin
                  if (htmr == REP_LAST) begin
                    rep_q <= 1'b1;
                    htmr  <= '0;
                  end else begin
                    htmr <= htmr + 1'b1;
                  end
                end
              end
              default: begin
                state <= H_IDLE;
                htmr  <= '0;
              end
            endcase
          end
        end
      end

      assign pb_long[g] = long_q;
      assign pb_rep[g]  = rep_q;
    end else begin : g_nohold
      assign pb_long[g] = 1'b0;
      assign pb_rep[g]  = 1'b0;
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
module tb_debounce_bank;

  localparam int LONG = 64;
  localparam int REP  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rst_n6 = 1'b0;
  logic [3:0] pb = 4'hF;
  logic [3:0] pb6 = 4'hF;

  logic [3:0] a_state, a_down, a_up, a_long, a_rep;
  logic [3:0] b_state, b_down, b_up, b_long, b_rep;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debounce_bank dut_a (
    .clk(clk), .rst_n(rst_n), .pb(pb),
    .pb_state(a_state), .pb_down(a_down), .pb_up(a_up),
    .pb_long(a_long), .pb_rep(a_rep)
  );

  debounce_bank #(.PRESCALE(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n6), .pb(pb6),
    .pb_state(b_state), .pb_down(b_down), .pb_up(b_up),
    .pb_long(b_long), .pb_rep(b_rep)
  );

  // ---------------------------------------------------------------------------
  // Behavioural model: per channel, count sample ticks during which the
  // synchronised input has disagreed with the accepted level, and count ticks
  // since the accepted press to place long/repeat pulses arithmetically.
  // Index 0 = default instance, 1 = PRESCALE=4 / CNT_W=2 instance.
  // ---------------------------------------------------------------------------
  int         m_cyc [2];
  logic [3:0] m_s0 [2];
  logic [3:0] m_s1 [2];
  logic [3:0] m_state [2];
  int         m_run [2][4];
  int         m_held [2][4];
  logic [3:0] e_state [2];
  logic [3:0] e_down [2];
  logic [3:0] e_up [2];
  logic [3:0] e_long [2];
  logic [3:0] e_rep [2];

  function automatic int pres(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic int nstab(input int d);
    return (d == 0) ? 16 : 4;
  endfunction

  task automatic model_reset(input int d);
    m_cyc[d] = 0;
    m_s0[d] = '0; m_s1[d] = '0; m_state[d] = '0;
    e_state[d] = '0; e_down[d] = '0; e_up[d] = '0; e_long[d] = '0; e_rep[d] = '0;
    for (int c = 0; c < 4; c++) begin
      m_run[d][c]  = 0;
      m_held[d][c] = -1;
    end
  endtask

  task automatic model_step(input int d, input logic [3:0] pbv);
    bit tick;
    tick = ((m_cyc[d] % pres(d)) == pres(d) - 1);
    m_cyc[d]++;
    e_down[d] = '0; e_up[d] = '0; e_long[d] = '0; e_rep[d] = '0;
    for (int c = 0; c < 4; c++) begin
      if (m_s1[d][c] == m_state[d][c]) begin
        m_run[d][c] = 0;
      end else if (tick) begin
        m_run[d][c]++;
        if (m_run[d][c] == nstab(d)) begin
          m_run[d][c] = 0;
          m_state[d][c] = ~m_state[d][c];
          if (m_state[d][c]) e_down[d][c] = 1'b1;
          else               e_up[d][c]   = 1'b1;
        end
      end
      if (e_up[d][c]) begin
        m_held[d][c] = -1;
      end else if (e_down[d][c]) begin
        m_held[d][c] = 0;
      end else if (m_held[d][c] >= 0 && tick) begin
        m_held[d][c]++;
        if (m_held[d][c] == LONG)
          e_long[d][c] = 1'b1;
        else if (m_held[d][c] > LONG && ((m_held[d][c] - LONG) % REP) == 0)
          e_rep[d][c] = 1'b1;
      end
    end
    e_state[d] = m_state[d];
    m_s1[d] = m_s0[d];
    m_s0[d] = ~pbv;
  endtask

  initial begin
    model_reset(0);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset(0);
      else        model_step(0, pb);
    end
  end

  initial begin
    model_reset(1);
    forever begin
      @(posedge clk or negedge rst_n6);
      if (!rst_n6) model_reset(1);
      else         model_step(1, pb6);
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check_vec(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check_vec("a_state", a_state, e_state[0]);
    check_vec("a_down",  a_down,  e_down[0]);
    check_vec("a_up",    a_up,    e_up[0]);
    check_vec("a_long",  a_long,  e_long[0]);
    check_vec("a_rep",   a_rep,   e_rep[0]);
    check_vec("b_state", b_state, e_state[1]);
    check_vec("b_down",  b_down,  e_down[1]);
    check_vec("b_up",    b_up,    e_up[1]);
    check_vec("b_long",  b_long,  e_long[1]);
    check_vec("b_rep",   b_rep,   e_rep[1]);
  end

  function automatic logic sel_bit(input int sel, input int ch);
    case (sel)
      0:       return a_down[ch];
      1:       return a_up[ch];
      2:       return b_down[ch];
      3:       return b_up[ch];
      default: return 1'b0;
    endcase
  endfunction

  // Returns the number of negedges until the selected pulse is seen, or -1.
  task automatic wait_bit(input int sel, input int ch, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sel_bit(sel, ch) && n < limit);
    if (!sel_bit(sel, ch)) n = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    logic [3:0] acc;
    int long_at[$];
    int rep_at[$];

    // Reset with all buttons released (pb high).
    repeat (3) @(negedge clk);
    check_vec("rst_a_outputs", a_state | a_down | a_up | a_long | a_rep, 4'h0);
    check_vec("rst_b_outputs", b_state | b_down | b_up | b_long | b_rep, 4'h0);
    #1 rst_n = 1'b1; rst_n6 = 1'b1;

    acc = '0;
    repeat (100) begin
      @(negedge clk);
      acc = acc | a_state | a_down | a_up | a_long | a_rep;
    end
    check_vec("quiet_after_reset", acc, 4'h0);

    // Clean press/release on ch0.
    pb[0] = 1'b0;
    wait_bit(0, 0, 100, n);
    check_int("ch0_down_latency", n, 18);
    check_int("ch0_state_at_down", int'(a_state[0]), 1);
    @(negedge clk);
    check_int("ch0_down_width", int'(a_down[0]), 0);
    repeat (4) @(negedge clk);
    pb[0] = 1'b1;
    wait_bit(1, 0, 100, n);
    check_int("ch0_up_latency", n, 18);
    repeat (5) @(negedge clk);

    // Bouncing ch1 never settles long enough.
    acc = '0;
    for (int k = 0; k < 5; k++) begin
      pb[1] = 1'b0;
      repeat (10) begin @(negedge clk); acc = acc | a_state | a_down; end
      pb[1] = 1'b1;
      repeat (3) begin @(negedge clk); acc = acc | a_state | a_down; end
    end
    check_vec("ch1_bounce_rejected", acc, 4'h0);
    pb[1] = 1'b0;
    wait_bit(0, 1, 100, n);
    check_int("ch1_settle_latency", n, 18);
    pb[1] = 1'b1;
    wait_bit(1, 1, 100, n);
    check_int("ch1_up_latency", n, 18);
    repeat (5) @(negedge clk);

    // Long hold on ch2 with auto-repeat.
    pb[2] = 1'b0;
    wait_bit(0, 2, 100, n);
    check_int("ch2_down_latency", n, 18);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (a_long[2]) long_at.push_back(k);
      if (a_rep[2])  rep_at.push_back(k);
    end
    check_int("ch2_long_count", long_at.size(), 1);
    if (long_at.size() > 0) check_int("ch2_long_offset", long_at[0], 64);
    check_int("ch2_rep_count", rep_at.size(), 8);
    foreach (rep_at[i]) check_int("ch2_rep_offset", rep_at[i], 80 + 16 * i);
    pb[2] = 1'b1;
    wait_bit(1, 2, 100, n);
    check_int("ch2_up_latency", n, 18);
    acc = '0;
    repeat (100) begin @(negedge clk); acc = acc | a_long | a_rep; end
    check_vec("ch2_quiet_after_up", acc, 4'h0);

    // ch0 and ch3 pressed together; ch3 release lands on its long-press cycle.
    pb[0] = 1'b0; pb[3] = 1'b0;
    wait_bit(0, 0, 100, n);
    check_int("ch0_ch3_down_latency", n, 18);
    check_int("ch3_down_same_cycle", int'(a_down[3]), 1);
    repeat (46) @(negedge clk);
    pb[3] = 1'b1;
    repeat (18) @(negedge clk);
    check_int("ch3_up_at_long", int'(a_up[3]), 1);
    check_int("ch3_long_suppressed", int'(a_long[3]), 0);
    check_int("ch0_long_unaffected", int'(a_long[0]), 1);
    pb[0] = 1'b1;
    wait_bit(1, 0, 100, n);
    check_int("ch0_up_after_long", n, 18);
    repeat (5) @(negedge clk);

    // Prescaled instance: latency window, then async reset while held.
    pb6[0] = 1'b0;
    wait_bit(2, 0, 100, n);
    check_int("pre_down_in_window", int'(n >= 15 && n <= 21), 1);
    repeat (8) @(negedge clk);
    check_int("pre_state_held", int'(b_state[0]), 1);
    #1 rst_n6 = 1'b0;
    #1 check_vec("pre_async_clear", b_state | b_down | b_up | b_long | b_rep, 4'h0);
    repeat (2) @(negedge clk);
    #1 rst_n6 = 1'b1;
    wait_bit(2, 0, 100, n);
    check_int("pre_refire_latency", n, 16);
    pb6[0] = 1'b1;
    wait_bit(3, 0, 100, n);
    check_int("pre_up_in_window", int'(n >= 15 && n <= 21), 1);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
